// File: rtl/window_det_pkg.sv
// Shared types for the sliding-window ones detector.
package window_det_pkg;

  typedef enum logic [1:0] {
    DET_EVEN     = 2'b00,
    DET_ODD      = 2'b01,
    DET_EXACT    = 2'b10,
    DET_AT_LEAST = 2'b11
  } det_mode_e;

endpackage

// File: rtl/window_ones_detector_bit_window.sv
// Shift register of the last WIN accepted bits plus a saturating fill counter.
module bit_window #(
  parameter  int WIN = 3,
  localparam int FW  = $clog2(WIN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic           clr,
  input  logic           din,
  output logic [WIN-1:0] win,
  output logic           oldest,
  output logic           full,
  output logic [FW-1:0]  fill_cnt
);

  logic [WIN-1:0] win_q, win_d;
  logic [FW-1:0]  fill_q, fill_d;

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_en) begin
      win_d = {win_q[WIN-2:0], din};
      if (fill_q != FW'(WIN)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  assign win      = win_q;
  assign oldest   = win_q[WIN-1];
  assign full     = (fill_q == FW'(WIN));
  assign fill_cnt = fill_q;

endmodule

// File: rtl/window_ones_detector.sv
// Sliding-window ones detector: incremental ones count and a registered mode compare.
module window_ones_detector
  import window_det_pkg::*;
#(
  parameter  int WIN   = 3,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] target,
  output logic             out_valid,
  output logic             match,
  output logic [CNT_W-1:0] ones_count,
  output logic             window_full
);

  logic             accept;
  logic [WIN-1:0]   win_unused;
  logic             oldest;
  logic             full;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             match_q, match_d;
  logic             hit;

  assign accept = in_valid & ~clear;

  bit_window #(.WIN(WIN)) u_bit_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (clear),
    .din      (in_bit),
    .win      (win_unused),
    .oldest   (oldest),
    .full     (full),
    .fill_cnt (fill_cnt)
  );

  // The oldest bit only leaves the count once the window is full; before that it is a reset zero.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(in_bit) - CNT_W'(full & oldest);
      vld_d = full | (fill_cnt == CNT_W'(WIN - 1));
    end
  end

  always_comb begin
    hit = 1'b0;
    case (det_mode_e'(mode))
      DET_EVEN:     hit = ~cnt_d[0];
      DET_ODD:      hit = cnt_d[0];
      DET_EXACT:    hit = (cnt_d == target);
      DET_AT_LEAST: hit = (cnt_d >= target);
      default:      hit = 1'b0;
    endcase
    match_d = vld_d & hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      match_q <= match_d;
    end
  end

  assign out_valid   = vld_q;
  assign match       = match_q;
  assign ones_count  = cnt_q;
  assign window_full = full;

endmodule

// File: tb/tb_window_ones_detector.sv
// Runs six detector widths on one shared stream against a bit-history scoreboard.
module tb_window_ones_detector;

  localparam int NI = 6;

  function automatic int win_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 5;
      4:       return 8;
      default: return 16;
    endcase
  endfunction

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       clear;
  logic [1:0] mode;
  logic [4:0] tgt;
  logic       ov [NI];
  logic       mt [NI];
  logic [4:0] oc [NI];
  logic       wf [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W  = win_of(g);
    localparam int CW = $clog2(W + 1);
    logic [CW-1:0] cnt;
    window_ones_detector #(.WIN(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .clear       (clear),
      .mode        (mode),
      .target      (tgt[CW-1:0]),
      .out_valid   (ov[g]),
      .match       (mt[g]),
      .ones_count  (cnt),
      .window_full (wf[g])
    );
    assign oc[g] = 5'(cnt);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: every bit accepted since the last reset/clear, plus what the last edge saw.
  bit   hist [$];
  bit   acc_l;
  int   mode_l;
  int   tgt_l;

  function automatic int exp_cnt(input int w);
    int n  = 0;
    int s  = hist.size();
    int lo = (s > w) ? s - w : 0;
    for (int k = lo; k < s; k++) n += int'(hist[k]);
    return n;
  endfunction

  function automatic bit exp_hit(input int m, input int c, input int t);
    case (m)
      0:       return (c % 2) == 0;
      1:       return (c % 2) == 1;
      2:       return c == t;
      default: return c >= t;
    endcase
  endfunction

  task automatic step(input bit v, input bit b, input bit c, input logic [1:0] m,
                      input logic [4:0] t);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    mode     = m;
    tgt      = t;
    if (c) hist.delete();
    else if (v) begin
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    acc_l  = v && !c;
    mode_l = int'(m);
    tgt_l  = int'(t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    mode     = 2'b00;
    tgt      = 5'd0;
    #3;
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (ov[i] !== 1'b0 || mt[i] !== 1'b0 || oc[i] !== 5'd0 || wf[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state win=%0d got ov=%b mt=%b cnt=%0d full=%b exp all 0",
                 win_of(i), ov[i], mt[i], oc[i], wf[i]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
    acc_l = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 2'b00, 5'd0);
    tests++;
    if (ov[1] !== 1'b1 || oc[1] !== 5'd3) begin
      fails++;
      $display("FAIL pre_reset_stream got ov=%b cnt=%0d exp ov=1 cnt=3", ov[1], oc[1]);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (ov[i] !== 1'b0 || mt[i] !== 1'b0 || oc[i] !== 5'd0 || wf[i] !== 1'b0) begin
        fails++;
        $display("FAIL async_reset win=%0d got ov=%b mt=%b cnt=%0d full=%b exp all 0",
                 win_of(i), ov[i], mt[i], oc[i], wf[i]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
    acc_l = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'b00, 5'd0);
      tests++;
      if (ov[1] !== (k == 3) || wf[1] !== (k == 3) || oc[1] !== 5'(k)) begin
        fails++;
        $display("FAIL refill_after_reset k=%0d got ov=%b full=%b cnt=%0d exp ov=%0d full=%0d cnt=%0d",
                 k, ov[1], wf[1], oc[1], k == 3, k == 3, k);
      end
    end
  endtask

  task automatic test_two_of_three;
    int bits [6];
    int e_cnt [6];
    int e_mt [6];
    bits  = '{1, 1, 0, 1, 0, 0};
    // Window {0,1,0} after the fifth bit holds a single one.
    e_cnt = '{1, 2, 2, 2, 1, 1};
    e_mt  = '{0, 0, 1, 1, 0, 0};
    step(1'b0, 1'b0, 1'b1, 2'b10, 5'd2);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'(bits[k]), 1'b0, 2'b10, 5'd2);
      tests++;
      if (ov[1] !== (k >= 2) || mt[1] !== 1'(e_mt[k]) || oc[1] !== 5'(e_cnt[k])) begin
        fails++;
        $display("FAIL two_of_three accept=%0d got ov=%b mt=%b cnt=%0d exp ov=%0d mt=%0d cnt=%0d",
                 k + 1, ov[1], mt[1], oc[1], k >= 2, e_mt[k], e_cnt[k]);
      end
    end
  endtask

  task automatic test_even_win8;
    step(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'b00, 5'd0);
      tests++;
      if (wf[4] !== (k == 8) || ov[4] !== (k == 8) || mt[4] !== (k == 8) || oc[4] !== 5'(k)) begin
        fails++;
        $display("FAIL even_w8_ones k=%0d got full=%b ov=%b mt=%b cnt=%0d exp full=%0d ov=%0d mt=%0d cnt=%0d",
                 k, wf[4], ov[4], mt[4], oc[4], k == 8, k == 8, k == 8, k);
      end
    end
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
    tests++;
    if (ov[4] !== 1'b1 || mt[4] !== 1'b0 || oc[4] !== 5'd7 || wf[4] !== 1'b1) begin
      fails++;
      $display("FAIL even_w8_zero got ov=%b mt=%b cnt=%0d full=%b exp ov=1 mt=0 cnt=7 full=1",
               ov[4], mt[4], oc[4], wf[4]);
    end
  endtask

  task automatic test_clear_collision;
    step(1'b0, 1'b0, 1'b1, 2'b01, 5'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 2'b01, 5'd0);
    step(1'b1, 1'b1, 1'b1, 2'b01, 5'd0);
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (ov[i] !== 1'b0 || mt[i] !== 1'b0 || oc[i] !== 5'd0 || wf[i] !== 1'b0) begin
        fails++;
        $display("FAIL clear_priority win=%0d got ov=%b mt=%b cnt=%0d full=%b exp all 0",
                 win_of(i), ov[i], mt[i], oc[i], wf[i]);
      end
    end
  endtask

  task automatic test_at_least_bounds;
    bit bits [12];
    for (int k = 0; k < 12; k++) bits[k] = 1'($urandom_range(0, 1));
    step(1'b0, 1'b0, 1'b1, 2'b11, 5'd5);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, bits[k], 1'b0, 2'b11, 5'd5);
      tests++;
      if (mt[2] !== 1'b0 || ov[2] !== (k >= 3)) begin
        fails++;
        $display("FAIL at_least_t5 k=%0d got mt=%b ov=%b exp mt=0 ov=%0d", k, mt[2], ov[2], k >= 3);
      end
    end
    step(1'b0, 1'b0, 1'b1, 2'b11, 5'd0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, bits[k], 1'b0, 2'b11, 5'd0);
      tests++;
      if (mt[2] !== (k >= 3) || ov[2] !== (k >= 3)) begin
        fails++;
        $display("FAIL at_least_t0 k=%0d got mt=%b ov=%b exp mt=%0d ov=%0d",
                 k, mt[2], ov[2], k >= 3, k >= 3);
      end
    end
  endtask

  task automatic test_random;
    int accepted = 0;
    int gap      = 0;
    bit v;
    bit c;
    while (accepted < 10000) begin
      v = (gap == 0);
      c = ($urandom_range(0, 199) == 0);
      step(v, 1'($urandom_range(0, 1)), c, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      if (v) begin
        accepted++;
        gap = $urandom_range(0, 5);
      end else begin
        gap--;
      end
      for (int i = 0; i < NI; i++) begin
        int w;
        int cw;
        int ec;
        bit ef;
        bit eo;
        bit em;
        w  = win_of(i);
        cw = $clog2(w + 1);
        ec = exp_cnt(w);
        ef = hist.size() >= w;
        eo = acc_l && ef;
        em = eo && exp_hit(mode_l, ec, tgt_l & ((1 << cw) - 1));
        tests++;
        if (ov[i] !== eo || mt[i] !== em || oc[i] !== 5'(ec) || wf[i] !== ef) begin
          fails++;
          $display("FAIL random win=%0d bit=%0d got ov=%b mt=%b cnt=%0d full=%b exp ov=%b mt=%b cnt=%0d full=%b",
                   w, accepted, ov[i], mt[i], oc[i], wf[i], eo, em, ec, ef);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_of_three();
    test_even_win8();
    test_clear_collision();
    test_at_least_bounds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
